// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants and types used by mont_convert and the other
// modular-arithmetic blocks (butterfly, twiddle multiplier).
package kyber_pkg;

    localparam int COEFF_W = 16;

    typedef logic signed [COEFF_W-1:0]   coeff_t;
    typedef logic signed [2*COEFF_W-1:0] prod_t;

    typedef enum logic {
        MODE_TO_MONT   = 1'b0,
        MODE_FROM_MONT = 1'b1
    } mode_e;

    localparam coeff_t KYBER_Q = 16'sd3329;
    localparam coeff_t QINV    = -16'sd3327;
    localparam coeff_t MONT    = -16'sd1044;
    localparam coeff_t R2      = 16'sd1353;

    function automatic prod_t sext(input coeff_t x);
        return {{COEFF_W{x[COEFF_W-1]}}, x};
    endfunction

endpackage

// File: rtl/mont_convert_if.sv
// Streaming valid/ready bundle for the Montgomery domain converter.
interface mont_convert_if;
    import kyber_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic               in_mode;
    coeff_t             in_data;
    logic               out_valid;
    logic               out_ready;
    logic [COEFF_W-1:0] out_data;
    logic               busy;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/mont_convert_fqmul_pipe.sv
// Three-stage Montgomery multiplier: out_u = a*b*2^-16 mod q, in (-q, q).
// All stages advance together under en; bubbles shift like valid beats.
module fqmul_pipe
    import kyber_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   in_valid,
    input  coeff_t in_a,
    input  coeff_t in_b,
    output logic   out_valid,
    output coeff_t out_u,
    output logic   busy
);

    logic   v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    prod_t  p1_q, p1_d, p2_q, p2_d;
    coeff_t t2_q, t2_d, u3_q, u3_d;
    prod_t  t_prod_s, diff_s;

    // Stage arithmetic and enable-gated next state for S1-S3
    always_comb begin
        t_prod_s = sext(coeff_t'(p1_q[15:0])) * sext(QINV);
        // Low half of diff_s is zero because t was chosen to cancel it
        diff_s   = p2_q - sext(t2_q) * sext(KYBER_Q);
        if (en) begin
            v1_d = in_valid;
            p1_d = sext(in_a) * sext(in_b);
            v2_d = v1_q;
            p2_d = p1_q;
            t2_d = coeff_t'(t_prod_s[15:0]);
            v3_d = v2_q;
            u3_d = coeff_t'(diff_s[31:16]);
        end else begin
            v1_d = v1_q;
            p1_d = p1_q;
            v2_d = v2_q;
            p2_d = p2_q;
            t2_d = t2_q;
            v3_d = v3_q;
            u3_d = u3_q;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            p1_q <= 32'sd0;
            p2_q <= 32'sd0;
            t2_q <= 16'sd0;
            u3_q <= 16'sd0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            p1_q <= p1_d;
            p2_q <= p2_d;
            t2_q <= t2_d;
            u3_q <= u3_d;
        end
    end

    assign out_valid = v3_q;
    assign out_u     = u3_q;
    assign busy      = v1_q | v2_q | v3_q;

endmodule

// File: rtl/mont_convert.sv
// Streaming normal <-> Montgomery domain converter for Kyber coefficients.
// Output is canonical in [0, q); one global enable stalls every stage.
module mont_convert
    import kyber_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mont_convert_if.slave bus
);

    logic               en_s;
    coeff_t             k_s;
    coeff_t             u_s;
    coeff_t             r_s;
    logic               u_valid_s;
    logic               pipe_busy_s;
    logic               out_valid_q, out_valid_d;
    logic [COEFF_W-1:0] out_data_q, out_data_d;

    assign en_s = !out_valid_q || bus.out_ready;

    // Multiplier selection: R^2 lands in a*R, 1 strips one R factor
    always_comb begin
        case (mode_e'(bus.in_mode))
            MODE_TO_MONT:   k_s = R2;
            MODE_FROM_MONT: k_s = 16'sd1;
            default:        k_s = R2;
        endcase
    end

    fqmul_pipe u_fqmul (
        .clk       (clk),
        .rst       (rst),
        .en        (en_s),
        .in_valid  (bus.in_valid),
        .in_a      (bus.in_data),
        .in_b      (k_s),
        .out_valid (u_valid_s),
        .out_u     (u_s),
        .busy      (pipe_busy_s)
    );

    // S4: fold (-q, q) into [0, q) and stage the output register
    always_comb begin
        if (u_s[COEFF_W-1]) begin
            r_s = u_s + KYBER_Q;
        end else begin
            r_s = u_s;
        end
        if (en_s) begin
            out_valid_d = u_valid_s;
            out_data_d  = r_s;
        end else begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
        end
    end

    // Output stage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 16'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = en_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = pipe_busy_s | out_valid_q;

endmodule

// File: tb/tb_mont_convert.sv
// Self-checking bench for mont_convert: directed vectors plus randomized streams
// checked against a modular-arithmetic reference model.
module tb_mont_convert;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mont_convert_if bif ();

    mont_convert dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int checks   = 0;
    int failures = 0;

    logic signed [15:0] drv_data[$];
    logic               drv_mode[$];
    logic [15:0]        got[$];
    int ready_viol, hold_viol, gaps, timeout, stall_seen;

    // Reference: mode 0 -> a*2^16 mod q, mode 1 -> a*169 mod q (169 = 2^-16 mod q)
    function automatic int ref_model(input logic signed [15:0] a, input logic mode);
        longint x;
        longint r;
        x = mode ? longint'(a) * 64'sd169 : longint'(a) * 64'sd65536;
        r = x % 64'sd3329;
        if (r < 0) r = r + 64'sd3329;
        return int'(r);
    endfunction

    // Drives every queued beat, collects outputs, records stall observations
    task automatic pump(input int stall_at, input int stall_len);
        int idx;
        int cyc;
        int last_out;
        logic was_stall;
        logic [15:0] held;
        idx = 0; cyc = 0; last_out = -1; was_stall = 1'b0; held = 16'd0;
        got.delete();
        ready_viol = 0; hold_viol = 0; gaps = 0; timeout = 0; stall_seen = 0;
        while (got.size() < drv_data.size()) begin
            @(negedge clk);
            if (cyc > 2 * drv_data.size() + 100) begin
                timeout = 1;
                break;
            end
            bif.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (idx < drv_data.size()) begin
                bif.in_valid = 1'b1;
                bif.in_data  = drv_data[idx];
                bif.in_mode  = drv_mode[idx];
            end else begin
                bif.in_valid = 1'b0;
            end
            #1;
            if (!bif.out_ready && bif.out_valid) begin
                stall_seen++;
                if (bif.in_ready !== 1'b0) ready_viol++;
                if (was_stall && bif.out_data !== held) hold_viol++;
                held = bif.out_data;
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (bif.out_valid && bif.out_ready) begin
                got.push_back(bif.out_data);
                if (last_out >= 0 && cyc != last_out + 1) gaps++;
                last_out = cyc;
            end
            if (bif.in_valid && bif.in_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bif.in_valid = 1'b0; bif.in_mode = 1'b0; bif.in_data = 16'sd0; bif.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.out_valid !== 1'b0 || bif.busy !== 1'b0 || bif.in_ready !== 1'b1 || bif.out_data !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b busy=%b ready=%b data=%0d, want 0 0 1 0",
                     bif.out_valid, bif.busy, bif.in_ready, bif.out_data);
        end
    endtask

    task automatic test_basic;
        logic signed [15:0] va[7] = '{16'sd1, 16'sd0, -16'sd1, 16'sd2285, 16'sd3328, -16'sd32768, 16'sd32767};
        logic               vm[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int                 ve[7] = '{2285, 0, 1044, 1, 3160, -1, -1};
        int lat;
        int exp;
        for (int i = 0; i < 7; i++) begin
            exp = (ve[i] < 0) ? ref_model(va[i], vm[i]) : ve[i];
            @(negedge clk);
            bif.in_valid = 1'b1; bif.in_data = va[i]; bif.in_mode = vm[i]; bif.out_ready = 1'b1;
            @(negedge clk);
            bif.in_valid = 1'b0;
            lat = 1;
            while (bif.out_valid !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat !== 4) begin
                failures++;
                $display("FAIL basic_latency[%0d]: got %0d cycles, want 4", i, lat);
            end
            checks++;
            if (int'(bif.out_data) !== exp || bif.out_data > 16'd3328) begin
                failures++;
                $display("FAIL basic_data[%0d] a=%0d mode=%0d: got %0d, want %0d",
                         i, va[i], vm[i], bif.out_data, exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stream;
        drv_data.delete(); drv_mode.delete();
        for (int i = 0; i < 64; i++) begin
            drv_data.push_back(16'($urandom));
            drv_mode.push_back(1'(i % 2));
        end
        pump(-100, 0);
        checks++;
        if (timeout !== 0 || got.size() !== 64) begin
            failures++;
            $display("FAIL stream_count: got %0d beats timeout=%0d, want 64 timeout=0", got.size(), timeout);
        end
        checks++;
        if (gaps !== 0) begin
            failures++;
            $display("FAIL stream_gaps: got %0d gaps, want 0", gaps);
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (int'(got[i]) !== ref_model(drv_data[i], drv_mode[i])) begin
                failures++;
                $display("FAIL stream_data[%0d]: got %0d, want %0d", i, got[i], ref_model(drv_data[i], drv_mode[i]));
            end
        end
    endtask

    task automatic test_backpressure;
        drv_data.delete(); drv_mode.delete();
        for (int i = 0; i < 40; i++) begin
            drv_data.push_back(16'($urandom));
            drv_mode.push_back(1'($urandom_range(0, 1)));
        end
        pump(20, 5);
        checks++;
        if (timeout !== 0 || got.size() !== 40) begin
            failures++;
            $display("FAIL bp_count: got %0d beats timeout=%0d, want 40 timeout=0", got.size(), timeout);
        end
        checks++;
        if (stall_seen !== 5 || ready_viol !== 0) begin
            failures++;
            $display("FAIL bp_in_ready: got stalls=%0d ready_high=%0d, want 5 0", stall_seen, ready_viol);
        end
        checks++;
        if (hold_viol !== 0) begin
            failures++;
            $display("FAIL bp_hold: got %0d data changes during stall, want 0", hold_viol);
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (int'(got[i]) !== ref_model(drv_data[i], drv_mode[i])) begin
                failures++;
                $display("FAIL bp_data[%0d]: got %0d, want %0d", i, got[i], ref_model(drv_data[i], drv_mode[i]));
            end
        end
    endtask

    task automatic test_reset_midstream;
        int stale;
        bif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bif.in_valid = 1'b1; bif.in_data = 16'($urandom); bif.in_mode = 1'b0;
        end
        @(negedge clk);
        bif.in_valid = 1'b0;
        checks++;
        if (bif.busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_busy_before: got %b, want 1", bif.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bif.out_valid !== 1'b0 || bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_flush: got valid=%b busy=%b, want 0 0", bif.out_valid, bif.busy);
        end
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (bif.out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL rst_stale: got %0d stale outputs, want 0", stale);
        end
        drv_data.delete(); drv_mode.delete();
        drv_data.push_back(16'sd1); drv_mode.push_back(1'b0);
        pump(-100, 0);
        checks++;
        if (got.size() !== 1 || got[0] !== 16'd2285) begin
            failures++;
            $display("FAIL rst_first_beat: got n=%0d data=%0d, want n=1 data=2285",
                     got.size(), (got.size() > 0) ? int'(got[0]) : -1);
        end
    endtask

    task automatic test_round_trip;
        logic [15:0] mont[$];
        drv_data.delete(); drv_mode.delete();
        for (int a = 0; a < 3329; a++) begin
            drv_data.push_back(16'(a));
            drv_mode.push_back(1'b0);
        end
        pump(-100, 0);
        mont = got;
        checks++;
        if (timeout !== 0 || mont.size() !== 3329) begin
            failures++;
            $display("FAIL rt_fwd_count: got %0d timeout=%0d, want 3329 0", mont.size(), timeout);
        end
        drv_data.delete(); drv_mode.delete();
        for (int i = 0; i < mont.size(); i++) begin
            checks++;
            if (int'(mont[i]) !== ref_model(16'(i), 1'b0)) begin
                failures++;
                $display("FAIL rt_fwd[%0d]: got %0d, want %0d", i, mont[i], ref_model(16'(i), 1'b0));
            end
            drv_data.push_back(mont[i]);
            drv_mode.push_back(1'b1);
        end
        pump(-100, 0);
        checks++;
        if (timeout !== 0 || got.size() !== mont.size()) begin
            failures++;
            $display("FAIL rt_back_count: got %0d timeout=%0d, want %0d 0", got.size(), timeout, mont.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (int'(got[i]) !== i) begin
                failures++;
                $display("FAIL rt_back[%0d]: got %0d, want %0d", i, got[i], i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_backpressure();
        test_reset_midstream();
        test_round_trip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mont_convert.md
Name: mont_convert

Overview:
- Streaming converter between normal and Montgomery domain for Kyber coefficients (q = 3329, R = 2^16).
- Converts to Montgomery form (a*R mod q) before NTT-domain multiplication, or back to normal form (a*R^-1 mod q) after it.
- Sits between the coefficient memory read port and the butterfly datapath.
- Fully pipelined with valid/ready backpressure; output is always canonical in [0, q).

Parameters:
- KYBER_Q, 3329, modulus q
- QINV, -3327, q^-1 mod 2^16 (signed 16-bit)
- R2, 1353, R^2 mod q (to-Montgomery multiplier)
- WIDTH, 16, coefficient width, signed two's complement

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- in_mode  in  1  0 = to Montgomery (a*R), 1 = from Montgomery (a*R^-1)
- in_data  in  WIDTH  signed coefficient, any int16 value
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  WIDTH  result, unsigned value in [0, q-1], upper bits zero
- busy  out  1  any pipeline stage holds a valid beat

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Handshake: transfer on valid & ready, both sides.
- Stall policy: global enable en = !out_valid | out_ready.
  - in_ready = en (combinational).
  - All stages advance only when en = 1.
  - in_valid must not depend on in_ready.
- Pipeline: 4 stages; each stage carries a valid bit and its mode bit.
  - S1: p = in_data * K (32-bit signed). K = R2 if mode = 0, K = 1 if mode = 1.
  - S2: t = low16(p) * QINV, truncated to signed 16 bits; p forwarded.
  - S3: u = (p - t*KYBER_Q) >>> 16. u is the signed 16-bit high half. The low 16 bits of the difference are zero by construction.
  - S4: r = u + KYBER_Q if u < 0, else u; registered as out_data.
- Range guarantee: |p| < q*2^15 for all int16 inputs, so -q < u < q and r is in [0, q). No further correction is needed.
- Latency: exactly 4 cycles from accepted input to out_valid when out_ready is held high.
- Throughput: 1 beat/cycle sustained.
- Backpressure: out_ready low with out_valid high freezes all stages and holds out_data stable. in_ready drops in the same cycle.
- Bubbles: an invalid stage still shifts when en = 1. Empty stages do not create backpressure because en depends only on the output stage.
- Mode: travels with each beat. Mixed-mode streams are legal back to back.
- Reset values:
  - all stage valid bits = 0; out_valid = 0
  - out_data = 0; all data and mode registers = 0
  - busy = 0; in_ready = 1 after reset
- Reset mid-operation: in-flight beats are dropped, not flushed. No output occurs in the cycle after rst deasserts.
- busy = OR of the S1-S4 valid bits.
- Widths: all products are computed in 32-bit signed. Sign extension of in_data and t is mandatory.

Decomposition:
- Shared package kyber_pkg holds KYBER_Q, QINV, MONT (-1044), R2 (1353) and the coefficient width. The same constants are used by the other arithmetic blocks.
- One sub-module is natural: fqmul_pipe, i.e. stages S1-S3 with enable and valid/mode sideband. It is later reused for twiddle multiplication.
- Stage S4 and the handshake logic stay in mont_convert.

Test Plan:
- Basic conversions, out_ready = 1:
  - mode 0, a = 1 -> out_data = 2285 after exactly 4 cycles
  - mode 0, a = 0 -> 0
  - mode 0, a = -1 -> 1044
- Inverse conversions:
  - mode 1, a = 2285 -> 1
  - mode 1, a = 3328 -> 3160
  - mode 1, a = -32768 and a = 32767 -> results equal (a*169) mod q, within [0, 3328]
- Streaming: 64 back-to-back beats, alternating mode, random int16 values -> one output per cycle, in order, each matching the reference model.
- Backpressure: hold out_ready = 0 for 5 cycles mid-stream -> in_ready = 0 in the same cycles, out_data stable, no beat lost or duplicated. Stream resumes seamlessly.
- Reset: assert rst with 3 beats in flight -> out_valid = 0, busy = 0 on the next cycle, no stale output afterwards. A first new beat with a = 1, mode 0 yields 2285.
- Round trip: mode 0 output fed back as mode 1 input for all a in [0, 3328] -> output equals a.
